// File: rtl/mem_dmem_ctrl.sv
// rtl/mem_dmem_ctrl.sv - MEM-stage data-memory controller on a req/ack 32-bit bus
module mem_dmem_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Rt_data_MEM,
    input  logic [63:0] Rt_data64_MEM,
    output logic        Stall_MEM,
    output logic [31:0] Read_data_MEM,
    output logic        Addr_err,
    output logic        Bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hold_q, hold_d;

    logic        cmd_rd, cmd_wr, cmd_wr64, cmd_any, aligned;
    logic        stall_c, addr_err_c, bus_err_c, timeout;
    logic [31:0] rdata_c;

    // MemWrite64 wins over MemWrite, which wins over MemRead
    assign cmd_wr64 = MemWrite64;
    assign cmd_wr   = !MemWrite64 && MemWrite;
    assign cmd_rd   = !MemWrite64 && !MemWrite && MemRead;
    assign cmd_any  = cmd_wr64 || cmd_wr || cmd_rd;
    assign aligned  = cmd_wr64 ? (Adrs_MEM[2:0] == 3'b000) : (Adrs_MEM[1:0] == 2'b00);
    assign timeout  = !dmem_ack && (cnt_q == CNT_MAX);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        stall_c    = 1'b0;
        addr_err_c = 1'b0;
        bus_err_c  = 1'b0;
        rdata_c    = hold_q;

        case (state_q)
            IDLE: begin
                if (cmd_any && !aligned) begin
                    addr_err_c = 1'b1;
                end else if (cmd_any) begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = !cmd_rd;
                    addr_d  = Adrs_MEM;
                    cnt_d   = 8'd0;
                    if (cmd_wr64) begin
                        wdata_d = Rt_data64_MEM[31:0];
                        state_d = WR_LO;
                    end else if (cmd_wr) begin
                        wdata_d = Rt_data_MEM;
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD, WR, WR_HI: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (state_q == RD) begin
                        hold_d  = dmem_rdata;
                        rdata_c = dmem_rdata;
                    end
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                    if (state_q == RD) begin
                        hold_d = 32'd0;
                    end
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            WR_LO: begin
                stall_c = !timeout;
                if (dmem_ack) begin
                    // second beat starts back-to-back with a fresh timeout window
                    addr_d  = addr_q + 32'd4;
                    wdata_d = Rt_data64_MEM[63:32];
                    cnt_d   = 8'd0;
                    state_d = WR_HI;
                end else if (timeout) begin
                    bus_err_c = 1'b1;
                    req_d     = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
        end
    end

    // combinational outputs are forced quiet while reset is held
    assign Stall_MEM     = stall_c && Rst_n;
    assign Addr_err      = addr_err_c && Rst_n;
    assign Bus_err       = bus_err_c && Rst_n;
    assign Read_data_MEM = Rst_n ? rdata_c : 32'd0;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;

endmodule
